// File: rtl/gfx256_fragment.sv
// gfx256_fragment: fragment stage behind clip/z-cull.
// Takes one pixel at a time. When texturing is enabled it fetches one texel through
// the wishbone reader (256-bit lines), drops colorkeyed texels, and hands the pixel
// to the blender over a write/ack handshake. It acks upstream once per pixel.
module gfx256_fragment #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // configuration
  input  logic                   texture_enable_i,
  input  logic [31:0]            tex0_base_i,
  input  logic [point_width-1:0] tex0_size_x_i,
  input  logic [point_width-1:0] tex0_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  // pixel from clip stage
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  // texture reader
  output logic [31:0]            texture_addr_o,
  output logic                   texture_request_o,
  input  logic                   texture_ack_i,
  input  logic [255:0]           texture_data_i,
  input  logic                   wbm_busy_i,
  // blender
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [7:0]             a_o,
  output logic [31:0]            color_o,
  output logic                   write_o,
  input  logic                   ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR1,
    ADDR2,
    TEX_READ,
    WRITE
  } state_t;

  localparam logic [point_width-1:0] one_pw = point_width'(1);

  state_t                 state;
  logic [point_width-1:0] u_r;
  logic [point_width-1:0] v_r;
  logic                   ck_en_r;
  logic [31:0]            ck_r;
  logic [1:0]             depth_r;
  logic [31:0]            offset_r;
  logic [4:0]             byte_off_r;

  logic [point_width-1:0]   size_x_m1;
  logic [point_width-1:0]   size_y_m1;
  logic [point_width-1:0]   u_c;
  logic [point_width-1:0]   v_c;
  logic [2*point_width-1:0] row_prod;
  logic [31:0]              lin_idx;
  logic [31:0]              offset_c;
  logic [287:0]             line_ext;
  logic [31:0]              texel_raw;
  logic [31:0]              texel;
  logic [31:0]              key_masked;
  logic                     keyed;

  // Clamp (u,v) into the texture and turn the texel index into a byte offset.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    size_x_m1 = tex0_size_x_i - one_pw;
    size_y_m1 = tex0_size_y_i - one_pw;
    u_c       = (u_r > size_x_m1) ? size_x_m1 : u_r;
    v_c       = (v_r > size_y_m1) ? size_y_m1 : v_r;
    row_prod  = {{point_width{1'b0}}, v_c} * {{point_width{1'b0}}, tex0_size_x_i};
    lin_idx   = 32'(row_prod) + 32'(u_c);
    case (color_depth_i)
      2'd0:    offset_c = lin_idx;
      2'd1:    offset_c = lin_idx << 1;
      default: offset_c = lin_idx << 2;
    endcase
  end

  // Pick the texel out of the returned line and compare it with the colorkey.
  always_comb begin
    // Zero padding above the line keeps the 32-bit window in range for any byte offset.
    line_ext  = {32'b0, texture_data_i};
    texel_raw = line_ext[{1'b0, byte_off_r, 3'b000} +: 32];
    case (depth_r)
      2'd0: begin
        texel      = {24'b0, texel_raw[7:0]};
        key_masked = {24'b0, ck_r[7:0]};
      end
      2'd1: begin
        texel      = {16'b0, texel_raw[15:0]};
        key_masked = {16'b0, ck_r[15:0]};
      end
      default: begin
        texel      = texel_raw;
        key_masked = ck_r;
      end
    endcase
    keyed = ck_en_r & (texel == key_masked);
  end

  // Pixel sequencing FSM. All outputs are registered.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments, so every read sees the pre-edge value.
    if (!rst_i) begin
      state             <= IDLE;
      ack_o             <= 1'b0;
      write_o           <= 1'b0;
      texture_request_o <= 1'b0;
      texture_addr_o    <= '0;
      pixel_x_o         <= '0;
      pixel_y_o         <= '0;
      pixel_z_o         <= '0;
      a_o               <= '0;
      color_o           <= '0;
      u_r               <= '0;
      v_r               <= '0;
      ck_en_r           <= 1'b0;
      ck_r              <= '0;
      depth_r           <= '0;
      offset_r          <= '0;
      byte_off_r        <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          // The ack_o gate stops the pixel that was just acked from being taken a second time.
          if (write_i && !ack_o) begin
            pixel_x_o <= pixel_x_i;
            pixel_y_o <= pixel_y_i;
            pixel_z_o <= pixel_z_i;
            a_o       <= a_i;
            color_o   <= color_i;
            u_r       <= u_i;
            v_r       <= v_i;
            ck_en_r   <= colorkey_enable_i;
            ck_r      <= colorkey_i;
            if (texture_enable_i && (tex0_size_x_i != '0) && (tex0_size_y_i != '0)) begin
              state <= ADDR1;
            end else begin
              write_o <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        ADDR1: begin
          offset_r <= offset_c;
          depth_r  <= color_depth_i;
          state    <= ADDR2;
        end
        ADDR2: begin
          texture_addr_o <= tex0_base_i + {5'b0, offset_r[31:5]};
          byte_off_r     <= offset_r[4:0];
          state          <= TEX_READ;
        end
        TEX_READ: begin
          if (!texture_request_o) begin
            // A new request may only start while the reader is idle.
            if (!wbm_busy_i) texture_request_o <= 1'b1;
          end else if (texture_ack_i) begin
            texture_request_o <= 1'b0;
            if (keyed) begin
              ack_o <= 1'b1;
              state <= IDLE;
            end else begin
              color_o <= texel;
              write_o <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (ack_i) begin
            write_o <= 1'b0;
            ack_o   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_fragment.sv
// Self-checking bench for gfx256_fragment. A behavioural model computes the clamped texel
// address, the texel bytes and the colorkey decision straight from the texture layout, and
// directed plus random pixels are compared against it.
module tb_gfx256_fragment;

  localparam int pw = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          texture_enable_i;
  logic [31:0]   tex0_base_i;
  logic [pw-1:0] tex0_size_x_i;
  logic [pw-1:0] tex0_size_y_i;
  logic [1:0]    color_depth_i;
  logic          colorkey_enable_i;
  logic [31:0]   colorkey_i;
  logic [pw-1:0] pixel_x_i;
  logic [pw-1:0] pixel_y_i;
  logic [pw-1:0] pixel_z_i;
  logic [pw-1:0] u_i;
  logic [pw-1:0] v_i;
  logic [7:0]    a_i;
  logic [31:0]   color_i;
  logic          write_i;
  logic          ack_o;
  logic [31:0]   texture_addr_o;
  logic          texture_request_o;
  logic          texture_ack_i;
  logic [255:0]  texture_data_i;
  logic          wbm_busy_i;
  logic [pw-1:0] pixel_x_o;
  logic [pw-1:0] pixel_y_o;
  logic [pw-1:0] pixel_z_o;
  logic [7:0]    a_o;
  logic [31:0]   color_o;
  logic          write_o;
  logic          ack_i;

  logic [255:0]  line;  // texture line the reader returns for the current pixel
  int            errors = 0;
  int            checks = 0;

  gfx256_fragment #(.point_width(pw)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .texture_enable_i(texture_enable_i), .tex0_base_i(tex0_base_i),
    .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
    .color_depth_i(color_depth_i), .colorkey_enable_i(colorkey_enable_i),
    .colorkey_i(colorkey_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
    .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i),
    .write_i(write_i), .ack_o(ack_o),
    .texture_addr_o(texture_addr_o), .texture_request_o(texture_request_o),
    .texture_ack_i(texture_ack_i), .texture_data_i(texture_data_i),
    .wbm_busy_i(wbm_busy_i),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
    .a_o(a_o), .color_o(color_o), .write_o(write_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [122:0] all_outputs();
    return {ack_o, texture_addr_o, texture_request_o, pixel_x_o, pixel_y_o, pixel_z_o,
            a_o, color_o, write_o};
  endfunction

  // Reference: a texture is a byte array of size_x*size_y texels, row-major, little-endian texels.
  function automatic void model(output logic et, output logic [31:0] ea, output logic [4:0] eb,
                                output logic [31:0] etex, output logic [31:0] ec,
                                output logic ek);
    int unsigned sx, sy, uc, vc, bpp, off, bo;
    logic [31:0] key;
    logic [255:0] sh;
    sx   = tex0_size_x_i;
    sy   = tex0_size_y_i;
    et   = texture_enable_i && sx != 0 && sy != 0;
    uc   = (u_i < sx) ? u_i : sx - 1;
    vc   = (v_i < sy) ? v_i : sy - 1;
    bpp  = (color_depth_i == 2'd0) ? 1 : (color_depth_i == 2'd1) ? 2 : 4;
    off  = (vc * sx + uc) * bpp;
    ea   = tex0_base_i + off / 32;
    bo   = off % 32;
    eb   = 5'(bo);
    etex = '0;
    for (int k = 0; k < int'(bpp); k++) begin
      sh   = line >> (8 * (bo + k));
      etex = etex | (32'(sh[7:0]) << (8 * k));
    end
    key  = (bpp == 4) ? colorkey_i : colorkey_i & ((32'd1 << (8 * bpp)) - 1);
    ek   = et && colorkey_enable_i && (etex == key);
    ec   = et ? etex : color_i;
  endfunction

  task automatic set_pixel(input logic ten, input logic [31:0] base, input int sx, input int sy,
                           input logic [1:0] depth, input logic cken, input logic [31:0] ck,
                           input int u, input int v, input logic [31:0] col);
    texture_enable_i  = ten;
    tex0_base_i       = base;
    tex0_size_x_i     = pw'(sx);
    tex0_size_y_i     = pw'(sy);
    color_depth_i     = depth;
    colorkey_enable_i = cken;
    colorkey_i        = ck;
    u_i               = pw'(u);
    v_i               = pw'(v);
    color_i           = col;
    pixel_x_i         = pw'($urandom);
    pixel_y_i         = pw'($urandom);
    pixel_z_i         = pw'($urandom);
    a_i               = 8'($urandom);
  endtask

  // Scramble configuration after it has been sampled; the pixel in flight must not notice.
  task automatic scramble_config();
    texture_enable_i  = 1'($urandom);
    tex0_base_i       = $urandom;
    tex0_size_x_i     = pw'($urandom);
    tex0_size_y_i     = pw'($urandom);
    color_depth_i     = 2'($urandom);
    colorkey_enable_i = 1'($urandom);
    colorkey_i        = $urandom;
  endtask

  // Drive one pixel through the stage and check every observable step.
  task automatic run_pixel(input string tag, input int busy_cyc, input int hold_cyc);
    logic        et, ek;
    logic [31:0] ea, etex, ec;
    logic [4:0]  eb;
    logic [pw*3+7:0] exp_pix;
    int n, exp_n;
    model(et, ea, eb, etex, ec, ek);
    exp_pix = {pixel_x_i, pixel_y_i, pixel_z_i, a_i};
    @(negedge clk_i);
    write_i    = 1'b1;
    wbm_busy_i = (busy_cyc > 0);
    n = 0;
    if (et) begin
      do begin
        @(negedge clk_i);
        n++;
        if (n >= busy_cyc) wbm_busy_i = 1'b0;
        if (n == 2) ack_i = 1'b1;  // blender ack outside WRITE is ignored
        else ack_i = 1'b0;
      end while (!texture_request_o && n < 60);
      ack_i = 1'b0;
      exp_n = ((busy_cyc > 3) ? busy_cyc : 3) + 1;
      check({tag, " req_latency"}, 256'(n), 256'(exp_n));
      check({tag, " tex_addr"}, 256'(texture_addr_o), 256'(ea));
      check({tag, " no_write_during_read"}, 256'({write_o, ack_o}), 256'(0));
      scramble_config();
      wbm_busy_i = 1'b1;
      @(negedge clk_i);
      check({tag, " req_held"}, 256'(texture_request_o), 256'(1));
      texture_ack_i  = 1'b1;
      texture_data_i = line;
      @(negedge clk_i);
      texture_ack_i  = 1'b0;
      texture_data_i = {8{$urandom}};
      wbm_busy_i     = 1'b0;
      check({tag, " req_dropped"}, 256'(texture_request_o), 256'(0));
      if (ek) begin
        check({tag, " keyed_ack"}, 256'({ack_o, write_o}), 256'(2'b10));
        @(negedge clk_i);
        write_i = 1'b0;
        check({tag, " keyed_after"}, 256'({ack_o, write_o}), 256'(0));
        return;
      end
    end else begin
      @(negedge clk_i);
      scramble_config();
      texture_ack_i = 1'b1;  // reader ack outside TEX_READ is ignored
    end
    check({tag, " write_o"}, 256'(write_o), 256'(1));
    check({tag, " color_o"}, 256'(color_o), 256'(ec));
    for (int h = 0; h < hold_cyc; h++) begin
      @(negedge clk_i);
      texture_ack_i = 1'b0;
      check({tag, " hold"}, 256'({write_o, ack_o, pixel_x_o, pixel_y_o, pixel_z_o, a_o, color_o}),
            256'({2'b10, exp_pix, ec}));
    end
    texture_ack_i = 1'b0;
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    check({tag, " ack_pulse"}, 256'({ack_o, write_o}), 256'(2'b10));
    @(negedge clk_i);  // write_i still high here: must not be re-accepted
    write_i = 1'b0;
    check({tag, " ack_single"}, 256'({ack_o, write_o}), 256'(0));
  endtask

  initial begin
    logic        et, ek;
    logic [31:0] ea, etex, ec, mask;
    logic [4:0]  eb;
    logic [1:0]  d;
    int n;

    rst_i = 1'b0; write_i = 1'b0; ack_i = 1'b0; texture_ack_i = 1'b0; wbm_busy_i = 1'b0;
    texture_data_i = '0; line = '0;
    set_pixel(1'b0, 32'h0, 0, 0, 2'd0, 1'b0, 32'h0, 0, 0, 32'h0);
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 256'(all_outputs()), 256'(0));
    rst_i = 1'b1;

    // 1: untextured pixel
    set_pixel(1'b0, 32'h0, 8, 8, 2'd2, 1'b0, 32'h0, 0, 0, 32'h0011_2233);
    pixel_x_i = 16'd5; pixel_y_i = 16'd7;
    run_pixel("t1_flat", 0, 2);

    // 2: 32bpp, base 0x1000, 64 wide, (3,2) -> line 0x1010, byte 12, word 3
    line = {8{$urandom}};
    line[127:96] = 32'hCAFE_F00D;
    set_pixel(1'b1, 32'h1000, 64, 64, 2'd2, 1'b0, 32'h0, 3, 2, 32'h0);
    model(et, ea, eb, etex, ec, ek);
    check("t2_addr_const", 256'(ea), 256'h1010);
    check("t2_byteoff_const", 256'(eb), 256'd12);
    run_pixel("t2_32bpp", 0, 1);

    // 3: 8bpp, u clamped to 99 -> byte 3 of line base+3
    line = {8{$urandom}};
    set_pixel(1'b1, 32'h200, 100, 10, 2'd0, 1'b0, 32'h0, 200, 0, 32'h0);
    run_pixel("t3_clamp8", 0, 1);

    // 4: colorkey hit on 16bpp texel 0xF81F
    line = {8{$urandom}};
    line[15:0] = 16'hF81F;
    set_pixel(1'b1, 32'h40, 32, 32, 2'd1, 1'b1, 32'h1234_F81F, 0, 0, 32'h0);
    run_pixel("t4_keyed", 0, 0);

    // 5: reader busy for 5 cycles, blender stalls 10 cycles
    line = {8{$urandom}};
    set_pixel(1'b1, 32'h8000, 50, 40, 2'd1, 1'b0, 32'h0, 17, 23, 32'h0);
    run_pixel("t5_busy_stall", 5, 10);

    // 6: reset in the middle of a texture read
    line = {8{$urandom}};
    set_pixel(1'b1, 32'h300, 16, 16, 2'd2, 1'b0, 32'h0, 4, 4, 32'h0);
    @(negedge clk_i);
    write_i = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!texture_request_o && n < 60);
    check("t6_req_before_reset", 256'(texture_request_o), 256'(1));
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_reset_outputs", 256'(all_outputs()), 256'(0));
    rst_i = 1'b1; write_i = 1'b0;
    @(negedge clk_i);
    check("t6_idle_after_reset", 256'(all_outputs()), 256'(0));
    set_pixel(1'b0, 32'h0, 0, 0, 2'd0, 1'b0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    run_pixel("t6_after_reset", 0, 1);

    // Random pixels: depth, sizes, clamping, keying and back-pressure all mixed.
    for (int i = 0; i < 40; i++) begin
      line = {8{$urandom}};
      d = 2'($urandom);
      set_pixel(($urandom_range(0, 3) != 0), $urandom_range(0, 32'hFFFF),
                ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 300),
                $urandom_range(1, 300), d, 1'($urandom), $urandom,
                $urandom_range(0, 400), $urandom_range(0, 400), $urandom);
      model(et, ea, eb, etex, ec, ek);
      if ($urandom_range(0, 2) == 0) begin
        mask = (d == 2'd0) ? 32'hFF : (d == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        colorkey_i = ($urandom & ~mask) | etex;
      end
      run_pixel("rand", $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
